// File: rtl/io_mmio_pkg.sv
// +--------------------------------------------------------------------------+
// | io_mmio_pkg : register map and constants for the mmio_io_ctrl peripheral  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package io_mmio_pkg;

  localparam logic [5:0] OFS_HEX   = 6'h00;
  localparam logic [5:0] OFS_LEDR  = 6'h04;
  localparam logic [5:0] OFS_LEDG  = 6'h08;
  localparam logic [5:0] OFS_KEY   = 6'h10;
  localparam logic [5:0] OFS_SW    = 6'h14;
  localparam logic [5:0] OFS_KSTAT = 6'h18;
  localparam logic [5:0] OFS_SSTAT = 6'h1C;
  localparam logic [5:0] OFS_CTRL  = 6'h20;

  localparam int CTRL_KIE = 0;
  localparam int CTRL_SIE = 1;

  localparam logic [31:0] BADREAD = 32'hDEADBEEF;

endpackage

`default_nettype wire

// File: rtl/io_debounce.sv
// +--------------------------------------------------------------------------+
// | io_debounce : 2-flop synchroniser plus per-bit stability counter          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module io_debounce #(
  parameter int W         = 1,
  parameter int DEBCYCLES = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_deb,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_chg
);

  localparam int                 c_cnt_w   = $clog2(DEBCYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBCYCLES - 1);

  logic [W-1:0] r_sync1;
  logic [W-1:0] r_sync2;
  logic [W-1:0] w_flip;
  logic [W-1:0] w_deb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar g = 0; g < W; g++) begin : g_bit
      logic [c_cnt_w-1:0] r_cnt;
      logic               r_deb;

      // Flip on the edge that completes DEBCYCLES consecutive mismatching samples.
      assign w_flip[g] = (r_sync2[g] != r_deb) && (r_cnt == c_cnt_max);
      assign w_deb[g]  = r_deb;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
          r_deb <= 1'b0;
        end else if (w_flip[g]) begin
          r_cnt <= '0;
          r_deb <= ~r_deb;
        end else if (r_sync2[g] != r_deb) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cnt <= '0;
        end
      end
    end
  endgenerate

  assign o_deb  = w_deb;
  assign o_rise = w_flip & ~w_deb;
  assign o_chg  = w_flip;

endmodule

`default_nettype wire

// File: rtl/mmio_io_ctrl.sv
// +--------------------------------------------------------------------------+
// | mmio_io_ctrl : memory-mapped HEX/LED/KEY/SW peripheral with sticky status |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mmio_io_ctrl #(
  parameter int                     DBITS     = 32,
  parameter logic [DBITS-1:0]       BASEADDR  = 32'hF0000000,
  parameter int                     NKEYS     = 4,
  parameter int                     NSW       = 10,
  parameter int                     NLEDR     = 10,
  parameter int                     NLEDG     = 8,
  parameter int                     HEXDIGITS = 4,
  parameter logic [4*HEXDIGITS-1:0] HEXRESET  = 16'hDEAD,
  parameter int                     DEBCYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DBITS-1:0]       addr_i,
  input  logic [DBITS-1:0]       wrdata_i,
  input  logic                   we_i,
  input  logic                   re_i,
  output logic [DBITS-1:0]       rddata_o,
  output logic                   hit_o,
  input  logic [NKEYS-1:0]       key_n_i,
  input  logic [NSW-1:0]         sw_i,
  output logic [4*HEXDIGITS-1:0] hex_o,
  output logic [NLEDR-1:0]       ledr_o,
  output logic [NLEDG-1:0]       ledg_o,
  output logic                   irq_o
);

  import io_mmio_pkg::*;

  logic [4*HEXDIGITS-1:0] r_hex;
  logic [NLEDR-1:0]       r_ledr;
  logic [NLEDG-1:0]       r_ledg;
  logic [NKEYS-1:0]       r_kstat;
  logic [NSW-1:0]         r_sstat;
  logic [1:0]             r_ctrl;
  logic                   r_irq;

  logic [NKEYS-1:0] w_key;
  logic [NKEYS-1:0] w_key_rise;
  logic [NKEYS-1:0] w_key_chg;
  logic [NSW-1:0]   w_sw;
  logic [NSW-1:0]   w_sw_rise;
  logic [NSW-1:0]   w_sw_chg;
  logic [5:0]       w_ofs;
  logic             w_in_win;
  logic             w_mapped;
  logic             w_wr;
  logic [NKEYS-1:0] w_kclr;
  logic [NSW-1:0]   w_sclr;
  logic             w_unused;

  io_debounce #(.W(NKEYS), .DEBCYCLES(DEBCYCLES)) u_deb_key (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (~key_n_i),
    .o_deb  (w_key),
    .o_rise (w_key_rise),
    .o_chg  (w_key_chg)
  );

  io_debounce #(.W(NSW), .DEBCYCLES(DEBCYCLES)) u_deb_sw (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (sw_i),
    .o_deb  (w_sw),
    .o_rise (w_sw_rise),
    .o_chg  (w_sw_chg)
  );

  // The window is 64-byte aligned; misaligned addresses never decode.
  assign w_ofs    = addr_i[5:0];
  assign w_in_win = (addr_i[DBITS-1:6] == BASEADDR[DBITS-1:6]) && (addr_i[1:0] == 2'b00);
  assign w_wr     = we_i && w_in_win;

  always_comb begin
    w_mapped = 1'b0;
    rddata_o = DBITS'(BADREAD);
    if (w_in_win) begin
      case (w_ofs)
        OFS_HEX:   begin w_mapped = 1'b1; rddata_o = DBITS'(r_hex);   end
        OFS_LEDR:  begin w_mapped = 1'b1; rddata_o = DBITS'(r_ledr);  end
        OFS_LEDG:  begin w_mapped = 1'b1; rddata_o = DBITS'(r_ledg);  end
        OFS_KEY:   begin w_mapped = 1'b1; rddata_o = DBITS'(w_key);   end
        OFS_SW:    begin w_mapped = 1'b1; rddata_o = DBITS'(w_sw);    end
        OFS_KSTAT: begin w_mapped = 1'b1; rddata_o = DBITS'(r_kstat); end
        OFS_SSTAT: begin w_mapped = 1'b1; rddata_o = DBITS'(r_sstat); end
        OFS_CTRL:  begin w_mapped = 1'b1; rddata_o = DBITS'(r_ctrl);  end
        default:   ;
      endcase
    end
  end

  assign hit_o  = (re_i || we_i) && w_mapped;
  assign w_kclr = (w_wr && w_ofs == OFS_KSTAT) ? wrdata_i[NKEYS-1:0] : '0;
  assign w_sclr = (w_wr && w_ofs == OFS_SSTAT) ? wrdata_i[NSW-1:0]   : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hex   <= HEXRESET;
      r_ledr  <= '0;
      r_ledg  <= '0;
      r_kstat <= '0;
      r_sstat <= '0;
      r_ctrl  <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr && w_ofs == OFS_HEX)  r_hex  <= wrdata_i[4*HEXDIGITS-1:0];
      if (w_wr && w_ofs == OFS_LEDR) r_ledr <= wrdata_i[NLEDR-1:0];
      if (w_wr && w_ofs == OFS_LEDG) r_ledg <= wrdata_i[NLEDG-1:0];
      if (w_wr && w_ofs == OFS_CTRL) r_ctrl <= wrdata_i[1:0];
      // A new event outranks a simultaneous write-one-to-clear.
      r_kstat <= (r_kstat & ~w_kclr) | w_key_rise;
      r_sstat <= (r_sstat & ~w_sclr) | w_sw_chg;
      r_irq   <= (r_ctrl[CTRL_KIE] && (|r_kstat)) || (r_ctrl[CTRL_SIE] && (|r_sstat));
    end
  end

  assign hex_o  = r_hex;
  assign ledr_o = r_ledr;
  assign ledg_o = r_ledg;
  assign irq_o  = r_irq;

  assign w_unused = ^{wrdata_i, w_key_chg, w_sw_rise};

endmodule

`default_nettype wire

// File: tb/tb_mmio_io_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_mmio_io_ctrl : directed + randomized bench with a register-level model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mmio_io_ctrl;

  localparam int          D    = 4;
  localparam logic [31:0] BASE = 32'hF0000000;

  logic        clk;
  logic        reset;
  logic [31:0] addr_i;
  logic [31:0] wrdata_i;
  logic        we_i;
  logic        re_i;
  logic [31:0] rddata_o;
  logic        hit_o;
  logic [3:0]  key_n_i;
  logic [9:0]  sw_i;
  logic [15:0] hex_o;
  logic [9:0]  ledr_o;
  logic [7:0]  ledg_o;
  logic        irq_o;

  int n_pass  = 0;
  int n_total = 0;
  bit armed   = 1'b0;

  mmio_io_ctrl #(.DEBCYCLES(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr_i   (addr_i),
    .wrdata_i (wrdata_i),
    .we_i     (we_i),
    .re_i     (re_i),
    .rddata_o (rddata_o),
    .hit_o    (hit_o),
    .key_n_i  (key_n_i),
    .sw_i     (sw_i),
    .hex_o    (hex_o),
    .ledr_o   (ledr_o),
    .ledg_o   (ledg_o),
    .irq_o    (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_hex;
  logic [9:0]  m_ledr, m_sw, m_sstat, nsw, schg, clrs;
  logic [7:0]  m_ledg;
  logic [3:0]  m_key, m_kstat, nkey, krise, clrk;
  logic [1:0]  m_ctrl;
  logic        m_irq;
  logic [3:0]  khist [0:D+1];
  logic [9:0]  shist [0:D+1];
  bit          ok;

  function automatic int woff(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    if (o < 32'd64 && o[1:0] == 2'b00) return int'(o);
    return -1;
  endfunction

  function automatic logic [32:0] mread(input logic [31:0] a);
    case (woff(a))
      'h00: return {1'b1, 16'h0, m_hex};
      'h04: return {1'b1, 22'h0, m_ledr};
      'h08: return {1'b1, 24'h0, m_ledg};
      'h10: return {1'b1, 28'h0, m_key};
      'h14: return {1'b1, 22'h0, m_sw};
      'h18: return {1'b1, 28'h0, m_kstat};
      'h1C: return {1'b1, 22'h0, m_sstat};
      'h20: return {1'b1, 30'h0, m_ctrl};
      default: return {1'b0, 32'hDEADBEEF};
    endcase
  endfunction

  // A debounced bit takes the opposite value once the raw input has read that
  // opposite value on each of the D samples ending two clocks ago.
  always @(posedge clk or posedge reset) begin : mdl
    if (reset) begin
      m_hex = 16'hDEAD; m_ledr = '0; m_ledg = '0; m_key = '0; m_sw = '0;
      m_kstat = '0; m_sstat = '0; m_ctrl = '0; m_irq = 1'b0;
      for (int j = 0; j <= D + 1; j++) begin khist[j] = '0; shist[j] = '0; end
    end else begin
      for (int j = D + 1; j > 0; j--) begin khist[j] = khist[j-1]; shist[j] = shist[j-1]; end
      khist[0] = ~key_n_i;
      shist[0] = sw_i;
      nkey = m_key;
      nsw  = m_sw;
      for (int b = 0; b < 4; b++) begin
        ok = 1'b1;
        for (int j = 2; j <= D + 1; j++) if (khist[j][b] == m_key[b]) ok = 1'b0;
        if (ok) nkey[b] = ~m_key[b];
      end
      for (int b = 0; b < 10; b++) begin
        ok = 1'b1;
        for (int j = 2; j <= D + 1; j++) if (shist[j][b] == m_sw[b]) ok = 1'b0;
        if (ok) nsw[b] = ~m_sw[b];
      end
      krise = nkey & ~m_key;
      schg  = nsw ^ m_sw;
      clrk  = '0;
      clrs  = '0;
      m_irq = (m_ctrl[0] && m_kstat != 0) || (m_ctrl[1] && m_sstat != 0);
      if (we_i) begin
        case (woff(addr_i))
          'h00: m_hex  = wrdata_i[15:0];
          'h04: m_ledr = wrdata_i[9:0];
          'h08: m_ledg = wrdata_i[7:0];
          'h18: clrk   = wrdata_i[3:0];
          'h1C: clrs   = wrdata_i[9:0];
          'h20: m_ctrl = wrdata_i[1:0];
          default: ;
        endcase
      end
      m_kstat = (m_kstat & ~clrk) | krise;
      m_sstat = (m_sstat & ~clrs) | schg;
      m_key   = nkey;
      m_sw    = nsw;
    end
  end

  logic [32:0] exp_rd;
  always @(negedge clk) begin
    if (armed) begin
      exp_rd = mread(addr_i);
      chk("hex_o",    32'(hex_o),  32'(m_hex));
      chk("ledr_o",   32'(ledr_o), 32'(m_ledr));
      chk("ledg_o",   32'(ledg_o), 32'(m_ledg));
      chk("irq_o",    32'(irq_o),  32'(m_irq));
      chk("rddata_o", rddata_o,    exp_rd[31:0]);
      chk("hit_o",    32'(hit_o),  32'(exp_rd[32] & (re_i | we_i)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr_i = a; wrdata_i = d; we_i = 1'b1;
    tick();
    we_i = 1'b0;
  endtask

  task automatic rdchk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    addr_i = a; re_i = 1'b1;
    #1;
    chk(nm, rddata_o, exp);
    re_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 19);
    if (k < 18) return BASE + 32'(k * 4);
    if (k == 18) return BASE + 32'($urandom_range(0, 63));
    return $urandom();
  endfunction

  int idx;

  initial begin
    reset = 1'b0; key_n_i = '1; sw_i = '0;
    addr_i = BASE; wrdata_i = '0; we_i = 1'b0; re_i = 1'b0;

    // 1: asynchronous reset mid-cycle
    #13 reset = 1'b1;
    #1 armed = 1'b1;
    chk("rst_hex",  32'(hex_o),  32'hDEAD);
    chk("rst_ledr", 32'(ledr_o), 32'h0);
    chk("rst_ledg", 32'(ledg_o), 32'h0);
    chk("rst_irq",  32'(irq_o),  32'h0);
    tick();
    reset = 1'b0;
    rdchk("rst_key", BASE + 32'h10, 32'h0);
    tick();

    // 2: output registers
    wr(BASE,          32'h1234ABCD);
    wr(BASE + 32'h4,  32'h000003FF);
    wr(BASE + 32'h8,  32'h000000A5);
    chk("hex_w",  32'(hex_o),  32'hABCD);
    chk("ledr_w", 32'(ledr_o), 32'h3FF);
    chk("ledg_w", 32'(ledg_o), 32'hA5);
    rdchk("hex_r",  BASE,         32'hABCD);
    rdchk("ledr_r", BASE + 32'h4, 32'h3FF);
    rdchk("ledg_r", BASE + 32'h8, 32'hA5);
    tick();

    // 3: debounce latency and glitch rejection
    key_n_i[2] = 1'b0;
    addr_i = BASE + 32'h10;
    tick(5);
    chk("key_lat5", rddata_o, 32'h0);
    tick(1);
    chk("key_lat6", rddata_o, 32'h4);
    rdchk("kstat_k2", BASE + 32'h18, 32'h4);
    tick();
    key_n_i[1] = 1'b0;
    tick(3);
    key_n_i[1] = 1'b1;
    tick(8);
    rdchk("key_glitch", BASE + 32'h10, 32'h4);
    rdchk("kstat_glitch", BASE + 32'h18, 32'h4);
    tick();

    // 4: key interrupt, W1C, set-beats-clear
    wr(BASE + 32'h18, 32'hF);
    rdchk("kstat_clr", BASE + 32'h18, 32'h0);
    wr(BASE + 32'h20, 32'h1);
    key_n_i[0] = 1'b0;
    tick(5);
    rdchk("kstat_pre", BASE + 32'h18, 32'h0);
    tick(1);
    rdchk("kstat_k0", BASE + 32'h18, 32'h1);
    chk("irq_pre", 32'(irq_o), 32'h0);
    tick(1);
    chk("irq_k0", 32'(irq_o), 32'h1);
    wr(BASE + 32'h18, 32'h1);
    rdchk("kstat_w1c", BASE + 32'h18, 32'h0);
    chk("irq_hold", 32'(irq_o), 32'h1);
    tick(1);
    chk("irq_clr", 32'(irq_o), 32'h0);
    key_n_i[0] = 1'b1;
    tick(8);
    rdchk("kstat_rel", BASE + 32'h18, 32'h0);
    key_n_i[0] = 1'b0;
    tick(5);
    wr(BASE + 32'h18, 32'h1);
    rdchk("kstat_setwins", BASE + 32'h18, 32'h1);
    tick(1);
    chk("irq_setwins", 32'(irq_o), 32'h1);

    // 5: switch events and read-only KEY
    wr(BASE + 32'h20, 32'h2);
    sw_i[9] = 1'b1;
    tick(6);
    rdchk("sstat_sw9", BASE + 32'h1C, 32'h200);
    rdchk("sw_sw9",    BASE + 32'h14, 32'h200);
    tick(1);
    chk("irq_sw", 32'(irq_o), 32'h1);
    wr(BASE + 32'h10, 32'h0);
    rdchk("key_ro", BASE + 32'h10, 32'h5);
    tick();

    // 6: unmapped / unaligned reads and read-during-write
    addr_i = BASE + 32'h24; re_i = 1'b1;
    #1 chk("unmap_rd", rddata_o, 32'hDEADBEEF);
    chk("unmap_hit", 32'(hit_o), 32'h0);
    addr_i = BASE + 32'h2;
    #1 chk("unalign_rd", rddata_o, 32'hDEADBEEF);
    chk("unalign_hit", 32'(hit_o), 32'h0);
    addr_i = BASE + 32'h8; wrdata_i = 32'h5A; we_i = 1'b1;
    #1 chk("rdw_old", rddata_o, 32'hA5);
    chk("rdw_hit", 32'(hit_o), 32'h1);
    tick();
    we_i = 1'b0; re_i = 1'b0;
    chk("rdw_new", 32'(ledg_o), 32'h5A);

    // randomized traffic checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      re_i     = 1'($urandom_range(0, 1));
      we_i     = ($urandom_range(0, 3) == 0);
      addr_i   = rand_addr();
      wrdata_i = $urandom();
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, 3);
        key_n_i[idx] = ~key_n_i[idx];
      end
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, 9);
        sw_i[idx] = ~sw_i[idx];
      end
      if (c == 1500) begin
        we_i = 1'b0;
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
